envelope_generator: RTL and testbench

- Per-voice ADSR amplitude stage directly downstream of the oscillator: takes one selected oscillator waveform sample and scales it by an attack/decay/sustain/release envelope.
- Drives the oscillator's clear input so phase restarts on a fresh note.
- Output feeds the voice mixer.
- Also reports voice activity to the voice allocator.

---
 rtl/config_pkg.sv | 4 +
 rtl/envelope_generator_pkg.sv | 17 +
 rtl/envelope_generator_scaler.sv | 46 ++++
 rtl/envelope_generator.sv | 125 ++++++++++++
 tb/tb_envelope_generator.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// Project-wide audio configuration shared by the oscillator, envelope and mixer blocks.
package CONFIG;
  localparam int AUDIO_BIT_WIDTH = 16;
endpackage

// File: rtl/envelope_generator_pkg.sv
// Envelope state encoding shared with the voice mixer and voice allocator.
package envelope_generator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

  // States in which the key is still considered held, so note_off starts a release.
  function automatic logic note_held(env_state_t state);
    return (state == ATTACK) || (state == DECAY) || (state == SUSTAIN);
  endfunction

endpackage

// File: rtl/envelope_generator_scaler.sv
// Two-stage offset-binary sample x unsigned gain multiplier; output is midpoint-centred.
module envelope_scaler #(
  parameter int SAMPLE_WIDTH = CONFIG::AUDIO_BIT_WIDTH,
  parameter int GAIN_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic [GAIN_WIDTH-1:0]   gain,
  output logic [SAMPLE_WIDTH-1:0] sample_out
);

  localparam int PROD_WIDTH = SAMPLE_WIDTH + GAIN_WIDTH + 1;
  localparam logic [SAMPLE_WIDTH-1:0] MIDPOINT = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic signed [SAMPLE_WIDTH:0] centered;
  logic signed [PROD_WIDTH-1:0] centered_ext;
  logic signed [PROD_WIDTH-1:0] gain_ext;
  logic signed [PROD_WIDTH-1:0] product_next;
  logic signed [PROD_WIDTH-1:0] product_reg;
  logic [SAMPLE_WIDTH-1:0]      scaled;
  logic [SAMPLE_WIDTH-1:0]      sample_out_reg;
  logic                         unused_product_bits;

  assign centered     = $signed({1'b0, sample_in}) - $signed({1'b0, MIDPOINT});
  assign centered_ext = $signed({{(PROD_WIDTH-SAMPLE_WIDTH-1){centered[SAMPLE_WIDTH]}}, centered});
  assign gain_ext     = $signed({{(PROD_WIDTH-GAIN_WIDTH){1'b0}}, gain});
  assign product_next = centered_ext * gain_ext;

  // Slicing above the fraction bits equals an arithmetic shift truncated to the sample width.
  assign scaled = product_reg[GAIN_WIDTH +: SAMPLE_WIDTH];
  assign unused_product_bits = ^{product_reg[GAIN_WIDTH-1:0], product_reg[PROD_WIDTH-1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      product_reg    <= '0;
      sample_out_reg <= MIDPOINT;
    end else begin
      product_reg    <= product_next;
      sample_out_reg <= MIDPOINT + scaled;
    end
  end

  assign sample_out = sample_out_reg;

endmodule

// File: rtl/envelope_generator.sv
// Per-voice ADSR envelope: tick-paced level FSM driving a pipelined sample scaler.
module envelope_generator
  import envelope_generator_pkg::*;
#(
  parameter int TICK_DIVIDER = 1000,
  parameter int ENV_WIDTH    = 16
) (
  input  logic                                clock_50_000_000,
  input  logic                                reset,
  input  logic                                note_on,
  input  logic                                note_off,
  input  logic [ENV_WIDTH-1:0]                attack_step,
  input  logic [ENV_WIDTH-1:0]                decay_step,
  input  logic [ENV_WIDTH-1:0]                sustain_level,
  input  logic [ENV_WIDTH-1:0]                release_step,
  input  logic [CONFIG::AUDIO_BIT_WIDTH-1:0]  wave_in,
  output logic                                osc_clear,
  output logic                                voice_active,
  output logic [ENV_WIDTH-1:0]                envelope,
  output logic [CONFIG::AUDIO_BIT_WIDTH-1:0]  wave_out
);

  localparam int CNT_WIDTH = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
  localparam logic [CNT_WIDTH-1:0] TICK_LAST  = CNT_WIDTH'(TICK_DIVIDER - 1);
  localparam logic [ENV_WIDTH-1:0] FULL_SCALE = '1;

  logic [CNT_WIDTH-1:0] tick_count_reg, tick_count_next;
  logic                 tick;
  env_state_t           state_reg, state_next;
  logic [ENV_WIDTH-1:0] env_reg, env_next;
  logic                 osc_clear_reg, osc_clear_next;

  // One extra bit catches overflow on the add and borrow on the subtracts.
  logic [ENV_WIDTH:0]   attack_sum;
  logic [ENV_WIDTH:0]   decay_diff;
  logic [ENV_WIDTH:0]   release_diff;

  assign tick            = (tick_count_reg == TICK_LAST);
  assign tick_count_next = tick ? '0 : tick_count_reg + CNT_WIDTH'(1);

  assign attack_sum   = {1'b0, env_reg} + {1'b0, attack_step};
  assign decay_diff   = {1'b0, env_reg} - {1'b0, decay_step};
  assign release_diff = {1'b0, env_reg} - {1'b0, release_step};

  always_comb begin
    state_next     = state_reg;
    env_next       = env_reg;
    osc_clear_next = 1'b0;
    if (note_on) begin
      // Retrigger keeps the current level; only a fresh note restarts the oscillator.
      state_next     = ATTACK;
      osc_clear_next = (state_reg == IDLE);
    end else if (note_off && note_held(state_reg)) begin
      state_next = RELEASE;
    end else begin
      unique case (state_reg)
        ATTACK: begin
          if (tick) begin
            if ((attack_step == '0) || attack_sum[ENV_WIDTH] ||
                (attack_sum[ENV_WIDTH-1:0] == FULL_SCALE)) begin
              env_next   = FULL_SCALE;
              state_next = DECAY;
            end else begin
              env_next = attack_sum[ENV_WIDTH-1:0];
            end
          end
        end
        DECAY: begin
          if (tick) begin
            if ((decay_step == '0) || decay_diff[ENV_WIDTH] ||
                (decay_diff[ENV_WIDTH-1:0] <= sustain_level)) begin
              env_next   = sustain_level;
              state_next = SUSTAIN;
            end else begin
              env_next = decay_diff[ENV_WIDTH-1:0];
            end
          end
        end
        SUSTAIN: env_next = sustain_level;
        RELEASE: begin
          if (tick) begin
            if ((release_step == '0) || release_diff[ENV_WIDTH] ||
                (release_diff[ENV_WIDTH-1:0] == '0)) begin
              env_next   = '0;
              state_next = IDLE;
            end else begin
              env_next = release_diff[ENV_WIDTH-1:0];
            end
          end
        end
        default: env_next = '0;
      endcase
    end
  end

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      tick_count_reg <= '0;
      state_reg      <= IDLE;
      env_reg        <= '0;
      osc_clear_reg  <= 1'b0;
    end else begin
      tick_count_reg <= tick_count_next;
      state_reg      <= state_next;
      env_reg        <= env_next;
      osc_clear_reg  <= osc_clear_next;
    end
  end

  assign osc_clear    = osc_clear_reg;
  assign voice_active = (state_reg != IDLE);
  assign envelope     = env_reg;

  envelope_scaler #(
    .SAMPLE_WIDTH(CONFIG::AUDIO_BIT_WIDTH),
    .GAIN_WIDTH  (ENV_WIDTH)
  ) u_scaler (
    .clock     (clock_50_000_000),
    .reset     (reset),
    .sample_in (wave_in),
    .gain      (env_reg),
    .sample_out(wave_out)
  );

endmodule

// File: tb/tb_envelope_generator.sv
// Scoreboard bench for envelope_generator: directed ADSR scenarios plus random note traffic.
module tb_envelope_generator;

  localparam int W    = CONFIG::AUDIO_BIT_WIDTH;
  localparam int E    = 16;
  localparam int TD   = 4;
  localparam int FULL = (1 << E) - 1;
  localparam int MID  = 1 << (W - 1);
  localparam int WMAX = (1 << W) - 1;
  localparam int S_IDLE = 0, S_ATTACK = 1, S_DECAY = 2, S_SUSTAIN = 3, S_RELEASE = 4;

  logic         clock_50_000_000 = 1'b0;
  logic         reset = 1'b1;
  logic         note_on = 1'b0, note_off = 1'b0;
  logic [E-1:0] attack_step = '0, decay_step = '0, sustain_level = '0, release_step = '0;
  logic [W-1:0] wave_in = W'(MID);
  logic         osc_clear, voice_active;
  logic [E-1:0] envelope;
  logic [W-1:0] wave_out;

  envelope_generator #(.TICK_DIVIDER(TD), .ENV_WIDTH(E)) dut (
    .clock_50_000_000(clock_50_000_000),
    .reset           (reset),
    .note_on         (note_on),
    .note_off        (note_off),
    .attack_step     (attack_step),
    .decay_step      (decay_step),
    .sustain_level   (sustain_level),
    .release_step    (release_step),
    .wave_in         (wave_in),
    .osc_clear       (osc_clear),
    .voice_active    (voice_active),
    .envelope        (envelope),
    .wave_out        (wave_out)
  );

  always #5 clock_50_000_000 = ~clock_50_000_000;

  typedef struct {
    int env;
    bit va;
    bit clr;
    int wave;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   clr_seen = 0;

  // Stimulus knobs, copied onto the DUT pins at each falling edge.
  int cfg_attack = 0, cfg_decay = 0, cfg_sustain = 0, cfg_release = 0, cfg_wave = MID;
  bit rand_wave = 1'b0;

  // Reference model: abstract ADSR phase/level plus a two-deep sample delay line.
  int     phase = S_IDLE, lvl = 0, edge_n = 0;
  longint s1 = MID, wv = MID;

  task automatic check(string name, longint act, longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, req);
    end
  endtask

  function automatic longint scale(longint w, longint e);
    longint prod;
    prod = (w - MID) * e;
    return MID + (prod >>> E);
  endfunction

  function automatic void model_reset();
    phase = S_IDLE; lvl = 0; edge_n = 0; s1 = MID; wv = MID;
  endfunction

  function automatic void model_edge(bit on, bit off);
    bit tick;
    bit clr;
    tick = ((edge_n % TD) == TD - 1);
    clr  = 1'b0;
    edge_n++;
    wv = s1;
    s1 = scale(cfg_wave, lvl);
    if (on) begin
      clr   = (phase == S_IDLE);
      phase = S_ATTACK;
    end else if (off && (phase == S_ATTACK || phase == S_DECAY || phase == S_SUSTAIN)) begin
      phase = S_RELEASE;
    end else begin
      case (phase)
        S_ATTACK: if (tick) begin
          lvl = (cfg_attack == 0 || lvl + cfg_attack >= FULL) ? FULL : lvl + cfg_attack;
          if (lvl == FULL) phase = S_DECAY;
        end
        S_DECAY: if (tick) begin
          lvl = (cfg_decay == 0 || lvl - cfg_decay <= cfg_sustain) ? cfg_sustain : lvl - cfg_decay;
          if (lvl == cfg_sustain) phase = S_SUSTAIN;
        end
        S_SUSTAIN: lvl = cfg_sustain;
        S_RELEASE: if (tick) begin
          lvl = (cfg_release == 0 || lvl - cfg_release <= 0) ? 0 : lvl - cfg_release;
          if (lvl == 0) phase = S_IDLE;
        end
        default: lvl = 0;
      endcase
    end
    exp_q.push_back('{lvl, phase != S_IDLE, clr, int'(wv)});
  endfunction

  task automatic step(bit on = 1'b0, bit off = 1'b0);
    @(negedge clock_50_000_000);
    if (rand_wave) cfg_wave = int'($urandom_range(0, WMAX));
    attack_step   = cfg_attack[E-1:0];
    decay_step    = cfg_decay[E-1:0];
    sustain_level = cfg_sustain[E-1:0];
    release_step  = cfg_release[E-1:0];
    wave_in       = cfg_wave[W-1:0];
    note_on       = on;
    note_off      = off;
    if (on || off)
      $display("note event at %0t: on=%0b off=%0b model phase=%0d level=0x%0h",
               $time, on, off, phase, lvl);
    model_edge(on, off);
  endtask

  // Observe the DUT after the edge that the last step() was aimed at.
  task automatic sample();
    @(posedge clock_50_000_000);
    #2;
  endtask

  task automatic run_until(int p, int v, string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(phase == p && lvl == v) && n < 200);
    if (!(phase == p && lvl == v)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: model phase %0d level 0x%0h, required phase %0d level 0x%0h",
               name, phase, lvl, p, v);
    end
  endtask

  task automatic release_reset();
    @(posedge clock_50_000_000);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  // Monitor: pops one expectation per clock edge and compares against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock_50_000_000);
      #1;
      if (osc_clear) clr_seen++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("envelope", envelope, e.env);
        check("voice_active", voice_active, e.va);
        check("osc_clear", osc_clear, e.clr);
        check("wave_out", wave_out, e.wave);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clock_50_000_000);
    #2;
    check("reset_envelope", envelope, 0);
    check("reset_voice_active", voice_active, 0);
    check("reset_wave_out", wave_out, MID);
    check("reset_osc_clear", osc_clear, 0);
    release_reset();

    // Full ADSR cycle.
    rand_wave = 1'b1;
    cfg_attack = 'h4000; cfg_decay = 'h1000; cfg_sustain = 'h8000; cfg_release = 'h2000;
    base = clr_seen;
    step(1'b1);
    run_until(S_DECAY, FULL, "adsr_attack");
    sample();
    check("adsr_peak", envelope, FULL);
    run_until(S_SUSTAIN, 'h8000, "adsr_decay");
    sample();
    check("adsr_sustain", envelope, 'h8000);
    check("adsr_osc_clear_pulses", clr_seen - base, 1);
    step(1'b0, 1'b1);
    run_until(S_IDLE, 0, "adsr_release");
    sample();
    check("adsr_idle_active", voice_active, 0);

    // Zero steps: jump to each target on the next tick.
    cfg_attack = 0; cfg_decay = 0; cfg_release = 0; cfg_sustain = 'h1234;
    step(1'b1);
    run_until(S_SUSTAIN, 'h1234, "zero_steps_decay");
    sample();
    check("zero_steps_sustain", envelope, 'h1234);
    step(1'b0, 1'b1);
    run_until(S_IDLE, 0, "zero_steps_release");

    // Asynchronous reset in the middle of an attack.
    cfg_attack = 'h4000; cfg_decay = 'h1000; cfg_sustain = 'h8000; cfg_release = 'h1000;
    step(1'b1);
    run_until(S_ATTACK, 'h4000, "reset_mid_attack");
    sample();
    check("pre_reset_envelope", envelope, 'h4000);
    reset = 1'b1;
    #1;
    check("async_reset_envelope", envelope, 0);
    check("async_reset_voice_active", voice_active, 0);
    check("async_reset_wave_out", wave_out, MID);
    repeat (2) @(posedge clock_50_000_000);
    base = clr_seen;
    release_reset();
    repeat (6) step();
    sample();
    check("post_reset_no_osc_clear", clr_seen - base, 0);

    // Retrigger during release keeps the level and does not clear the oscillator.
    step(1'b1);
    run_until(S_SUSTAIN, 'h8000, "retrig_setup");
    step(1'b0, 1'b1);
    run_until(S_RELEASE, 'h3000, "retrig_release");
    base = clr_seen;
    step(1'b1);
    run_until(S_ATTACK, 'h7000, "retrig_attack");
    sample();
    check("retrig_envelope", envelope, 'h7000);
    check("retrig_no_osc_clear", clr_seen - base, 0);

    // Simultaneous note_on and note_off in SUSTAIN: attack wins.
    run_until(S_SUSTAIN, 'h8000, "simul_setup");
    step(1'b1, 1'b1);
    run_until(S_ATTACK, 'hC000, "simul_attack");
    sample();
    check("simul_envelope", envelope, 'hC000);
    step(1'b0, 1'b1);
    run_until(S_IDLE, 0, "simul_release");

    // Scaling boundaries.
    rand_wave = 1'b0;
    cfg_wave = WMAX;
    step(); step();
    sample();
    check("scale_zero_env", wave_out, MID);
    cfg_attack = 0; cfg_sustain = FULL;
    step(1'b1);
    run_until(S_SUSTAIN, FULL, "scale_full_setup");
    step(); step();
    sample();
    check("scale_full_within_1lsb", (int'(wave_out) >= WMAX - 1), 1);
    cfg_sustain = 'h8000; cfg_wave = 0;
    step(); step(); step();
    sample();
    check("scale_half_env_min_wave", wave_out, MID / 2);
    step(1'b0, 1'b1);
    run_until(S_IDLE, 0, "scale_release");

    // Random note traffic with occasional parameter changes.
    rand_wave = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit on, off;
      if ($urandom_range(0, 199) == 0) begin
        cfg_attack  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 'h6000));
        cfg_decay   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 'h6000));
        cfg_release = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 'h6000));
      end
      if ($urandom_range(0, 99) == 0) cfg_sustain = int'($urandom_range(0, FULL));
      on  = ($urandom_range(0, 99) < 2);
      off = ($urandom_range(0, 99) < 3);
      step(on, off);
    end

    sample();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
